// File: rtl/alu_pkg.sv
// Shared ALU definitions for the M-extension execute path: operation
// encodings for the multiplier and divider, the multiplier state encoding
// and the datapath width.
package alu_pkg;

  localparam int XLEN = 64;

  // Multiplier operation select
  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  // Divider operation select
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_FIX  = 2'd2,
    MUL_DONE = 2'd3
  } mul_state_e;

  // rs1 is treated as signed for MULH and MULHSU
  function automatic logic mulSigned1(input logic [1:0] op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  // rs2 is treated as signed for MULH only
  function automatic logic mulSigned2(input logic [1:0] op);
    return (op == MUL_OP_MULH);
  endfunction

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier, one multiplier bit per cycle.
// Operands are reduced to magnitudes on acceptance; the product sign is
// restored in a single fix-up cycle before the selected half is registered.
module mul_seq #(
  parameter int XLEN = alu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic [1:0]      control,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out
);

  import alu_pkg::*;

  localparam int CW = $clog2(XLEN) + 1;

  mul_state_e        state_q, state_d;
  logic [1:0]        ctl_q, ctl_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   out_q, out_d;

  logic              sign1, sign2;
  logic [XLEN-1:0]   mag1, mag2;
  logic [XLEN:0]     addSum;
  logic [2*XLEN-1:0] product;

  // Operand magnitudes, partial-sum adder and sign-corrected product
  always_comb begin
    sign1   = mulSigned1(control) & in1[XLEN-1];
    sign2   = mulSigned2(control) & in2[XLEN-1];
    mag1    = sign1 ? (~in1 + 1'b1) : in1;
    mag2    = sign2 ? (~in2 + 1'b1) : in2;
    addSum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
    product = neg_q ? (~acc_q + 1'b1) : acc_q;
  end

  // Next-state logic for the FSM and datapath registers
  always_comb begin
    state_d = state_q;
    ctl_d   = ctl_q;
    neg_d   = neg_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    unique case (state_q)
      MUL_IDLE: begin
        if (in_valid && !kill) begin
          ctl_d   = control;
          neg_d   = sign1 ^ sign2;
          mcand_d = mag1;
          acc_d   = {{XLEN{1'b0}}, mag2};
          cnt_d   = '0;
          state_d = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        if (kill) begin
          state_d = MUL_IDLE;
        end else begin
          if (acc_q[0]) begin
            acc_d = {addSum, acc_q[XLEN-1:1]};
          end else begin
            acc_d = {1'b0, acc_q[2*XLEN-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN - 1)) begin
            state_d = MUL_FIX;
          end
        end
      end
      MUL_FIX: begin
        if (kill) begin
          state_d = MUL_IDLE;
        end else begin
          out_d   = (ctl_q == MUL_OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: begin
        if (kill || out_ready) begin
          state_d = MUL_IDLE;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MUL_IDLE;
      ctl_q   <= '0;
      neg_q   <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      neg_q   <= neg_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == MUL_IDLE);
  assign out_valid = (state_q == MUL_DONE);
  assign out       = out_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed testbench for mul_seq: a scoreboard queue holds expected results
// pushed at issue time and a negedge monitor compares them whenever the DUT
// presents a result.
module tb_mul_seq;

  localparam int W   = 64;
  localparam int LAT = W + 1;

  logic         clk;
  logic         rst;
  logic         kill;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [1:0]   control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;

  int vectorCount = 0;
  int missCount   = 0;
  logic [63:0] expQ[$];

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  ctl;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  mul_seq #(.XLEN(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .kill      (kill),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectorCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compare whenever a result is presented
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected out_valid", 64'(out_valid), 64'd0);
      end else if (out_ready) begin
        checkOutput("result", out, expQ.pop_front());
      end else begin
        checkOutput("held result", out, expQ[0]);
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the accepting edge
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               input logic [1:0] ctl, input logic [63:0] exp,
                               input bit expectResult);
    in1      = a;
    in2      = b;
    control  = ctl;
    in_valid = 1'b1;
    if (expectResult) expQ.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Returns at the negedge where out_valid is first seen (or after timeout)
  task automatic waitResult(input string name);
    int edges = 0;
    bit readyLeak = 1'b0;
    while (edges < 200) begin
      @(negedge clk);
      if (in_ready) readyLeak = 1'b1;
      if (out_valid) break;
      @(posedge clk); #1;
      edges++;
    end
    if (!out_valid) begin
      checkOutput({name, " timeout"}, 64'd0, 64'd1);
    end else begin
      checkOutput({name, " latency"}, 64'(edges), 64'(LAT));
    end
    checkOutput({name, " in_ready while busy"}, 64'(readyLeak), 64'd0);
  endtask

  task automatic watchQuiet(input string name, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput(name, 64'(seen), 64'd0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs.push_back('{64'd3, 64'd5, 2'b00, 64'h0000_0000_0000_000F});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b01, 64'h4000_0000_0000_0000});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 64'h0000_0000_0000_0000});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 64'hFFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 64'h0000_0000_0000_0001});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 64'h0000_0000_0000_0001});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'd1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b00, 64'h0000_0000_0000_0000});
    vecs.push_back('{64'd0, 64'h1234_5678_9ABC_DEF0, 2'b11, 64'h0000_0000_0000_0000});

    rst       = 1'b1;
    kill      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in1       = '0;
    in2       = '0;
    control   = 2'b00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset out", out, 64'd0);
    tick();
    rst = 1'b0;

    // Directed vectors with immediate consumption
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].ctl, vecs[i].exp, 1'b1);
      waitResult("vector");
      tick();
      checkOutput("in_ready after handshake", 64'(in_ready), 64'd1);
    end

    // Backpressure: result must be held while out_ready is low
    out_ready = 1'b0;
    applyStimulus(64'd7, 64'd6, 2'b00, 64'h2A, 1'b1);
    waitResult("backpressure");
    repeat (10) begin
      tick();
      @(negedge clk);
      checkOutput("out_valid held", 64'(out_valid), 64'd1);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    checkOutput("in_ready after release", 64'(in_ready), 64'd1);
    checkOutput("out_valid after release", 64'(out_valid), 64'd0);

    // Operands changing after acceptance must not disturb the result
    applyStimulus(64'd10, 64'd10, 2'b00, 64'h64, 1'b1);
    in1     = '1;
    in2     = '1;
    control = 2'b11;
    waitResult("operand change");
    tick();
    control = 2'b00;

    // kill has priority over in_valid while idle
    in1      = 64'd9;
    in2      = 64'd9;
    kill     = 1'b1;
    in_valid = 1'b1;
    tick();
    kill     = 1'b0;
    in_valid = 1'b0;
    checkOutput("kill in idle in_ready", 64'(in_ready), 64'd1);
    watchQuiet("kill in idle no result", 80);

    // Reset mid-operation
    tick();
    applyStimulus(64'd5, 64'd5, 2'b00, 64'd0, 1'b0);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("mid reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid reset out", out, 64'd0);
    watchQuiet("mid reset no result", 80);

    // kill mid-operation
    tick();
    applyStimulus(64'd11, 64'd13, 2'b00, 64'd0, 1'b0);
    repeat (30) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    @(negedge clk);
    checkOutput("kill busy in_ready", 64'(in_ready), 64'd1);
    checkOutput("kill busy out_valid", 64'(out_valid), 64'd0);
    watchQuiet("kill busy no result", 80);

    // Normal operation resumes after an abort
    tick();
    applyStimulus(64'd2, 64'd2, 2'b00, 64'd4, 1'b1);
    waitResult("after abort");
    tick();
    checkOutput("after abort in_ready", 64'(in_ready), 64'd1);

    repeat (3) tick();
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Multi-cycle 64-bit integer multiplier for the ALU M-extension path, the inverse operation to the combinational divider.
- Computes MUL, MULH, MULHSU and MULHU with a 1-bit-per-cycle shift-add datapath.
- Valid/ready handshakes on both the operand side and the result side.
- Sits beside the divider in the execute stage; the pipeline stalls while it is busy.

Parameters:
- XLEN, 64: operand and result width; iteration count equals XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- kill  input  1  abort the in-flight operation (pipeline flush)
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- in1  input  XLEN  multiplicand (rs1)
- in2  input  XLEN  multiplier (rs2)
- control  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out  output  XLEN  selected result half

Behaviour:
- Reset: synchronous active-high; state IDLE, in_ready=1, out_valid=0, out=0, counter=0, accumulator=0. Reset mid-operation discards all work.
- States: IDLE, BUSY, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge, latch control, the operand magnitudes, and neg = sign(in1)^sign(in2), then go to BUSY with counter=0.
  - Operand signedness: in1 is signed for 01 and 10; in2 is signed for 01 only. 00 is computed as unsigned, which gives the same low half.
  - Inputs may change freely after acceptance.
- BUSY:
  - in_ready=0.
  - Each edge: if the multiplier LSB is 1, add the multiplicand to the upper half of the 2*XLEN accumulator, then shift the accumulator/multiplier right by 1.
  - Counter increments; after XLEN edges go to FIX.
- FIX:
  - One edge: if neg is set, replace the product with its 2*XLEN two's complement.
  - Register out: low XLEN bits for 00, high XLEN bits otherwise.
  - Go to DONE.
- DONE:
  - out_valid=1 and out is stable until out_valid&&out_ready. On that edge go to IDLE and clear out_valid.
  - in_ready=0 throughout DONE; there is no same-edge accept.
- Latency: out_valid first visible XLEN+1 edges after the accepting edge, i.e. 65 edges at XLEN=64. Throughput is one operation per XLEN+3 cycles at minimum.
- kill:
  - In BUSY, FIX or DONE, the next edge returns to IDLE with out_valid=0; the result is dropped.
  - In IDLE, kill has priority over in_valid; nothing is accepted that cycle.
  - rst has priority over kill.
- Arithmetic:
  - 2*XLEN accumulator with an XLEN+1-bit adder carry. No overflow flags.
  - A most-negative operand is handled by its magnitude 2^(XLEN-1) in XLEN unsigned bits, which needs no extra bit.
- Zero operands take the full latency; there is no early-out.
- out is undefined-but-stable, holding its last value, whenever out_valid=0; the bench checks out only when out_valid=1.

Decomposition:
- Shared package (alu_pkg) holds:
  - MUL_OP_MUL/MULH/MULHSU/MULHU 2-bit encodings, alongside the existing DIV/DIVU/REM/REMU encodings;
  - the mul_seq state enum;
  - XLEN.
- No sub-module. The single FSM plus datapath stays one module; the sign fix-up is too small to split out.

Test Plan:
- MUL: in1=3, in2=5, control=00, out_ready=1 → out=0x000000000000000F; out_valid rises exactly 65 edges after accept; in_ready=0 during BUSY/FIX/DONE.
- MULH: in1=0x8000000000000000, in2=0x8000000000000000 → 0x4000000000000000. Then in1=in2=0xFFFFFFFFFFFFFFFF → 0x0000000000000000.
- MULHU: in1=in2=0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE. MULHSU with the same operands → 0xFFFFFFFFFFFFFFFF. MUL with the same operands → 0x0000000000000001.
- Backpressure: MUL 7*6 with out_ready=0 for 10 cycles after out_valid → out=0x2A stable and out_valid held. Once out_ready=1, returns to IDLE next edge and in_ready=1.
- Operand change after accept: accept MUL 10*10, then drive in1=in2=0xFFFF... for the whole BUSY period → out=0x64.
- Abort:
  - rst asserted at BUSY cycle 20 → next edge all outputs at reset values.
  - kill asserted at BUSY cycle 30 → IDLE, no out_valid pulse.
  - A new MUL 2*2 then yields 4 at normal latency.
